dmem_waitstate: RTL
===================

# dmem_waitstate

Data-memory responder for the MIPS core's memory-stage port. It answers the core's load/store requests (MemReadM/MemWriteM, ALUOutM, WriteDataM) after a configurable number of wait states. While a request is outstanding it drives a stall request to the hazard unit. It replaces the zero-latency data memory in the top-level integration, so pipeline stall paths can be exercised against a slow memory.

## Interface

Parameters:
- ADDR_BITS, 6 — word-address width; array depth is 2**ADDR_BITS 32-bit words.
- WAIT_CYCLES, 2 — stall cycles inserted per access; legal range 0..15.

Ports:
- clk  input  1  — single clock; all state updates on rising edge.
- reset  input  1  — asynchronous, active-low; clears all state immediately on assertion.
- MemReadM  input  1  — load request from the M stage.
- MemWriteM  input  1  — store request from the M stage.
- ALUOutM  input  32  — byte address; word index is ALUOutM[ADDR_BITS+1:2].
- WriteDataM  input  32  — store data.
- ReadDataM  output  32  — load data; valid in the completion cycle.
- StallMem  output  1  — 1 = hold the F/D/E/M stages; combinational from state and request.
- MemErr  output  1  — sticky misaligned-access flag (see Configuration).

## Operation

- Request: MemReadM | MemWriteM. If both are asserted, the access is treated as a store, and ReadDataM still returns the pre-store word.
- States: IDLE and WAIT, plus a 4-bit down-counter cnt.
- IDLE, no request: StallMem=0.
- IDLE, request, WAIT_CYCLES=0: complete in the same cycle; StallMem=0.
- IDLE, request, WAIT_CYCLES>0: StallMem=1, cnt<=WAIT_CYCLES-1, next state WAIT.
- WAIT, cnt!=0: StallMem=1, cnt<=cnt-1.
- WAIT, cnt==0 (completion cycle): StallMem=0, next state IDLE.
- Completion cycle, load: ReadDataM = mem[word index], combinational read.
- Completion cycle, store: mem[word index] <= WriteDataM at the closing rising edge.
- Outside the completion cycle, ReadDataM holds its last completed load value; it is 0 after reset.
- The core keeps ALUOutM, WriteDataM and the request bits stable while StallMem=1. The M stage advances whenever StallMem=0, so a request seen in IDLE is always a new access.
- If the request drops while in WAIT (protocol violation), return to IDLE next edge: no write, StallMem=0.
- Memory array contents are not reset.

## Timing

- Access latency: WAIT_CYCLES+1 cycles from request to completion.
- StallMem is high for exactly WAIT_CYCLES consecutive cycles per access.
- Back-to-back accesses: a request present in the cycle after completion starts a new access from IDLE. There is no idle bubble beyond the wait states.
- Reset asserted mid-access: state=IDLE, cnt=0, StallMem=0, ReadDataM=0, MemErr=0 immediately. A pending store is discarded.
- Reset deassertion: the first access can be accepted on the first rising edge after release.
- Addresses above the array wrap modulo 2**ADDR_BITS words; upper address bits are ignored.

## Configuration

- DMEM_WS_MISALIGN_TRAP_EN defined: a request with ALUOutM[1:0]!=0 still takes the full wait sequence. In the completion cycle the store is suppressed, ReadDataM is forced to 0, and MemErr is set and stays set until reset.
- Not defined: ALUOutM[1:0] is ignored, misaligned accesses behave as the aligned word, and MemErr is tied to 0.

## Test plan

- Reset held low with MemWriteM=1 -> StallMem=0, ReadDataM=0, MemErr=0; no array change. Release, then load address 0x0 -> reads pre-initialized value.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10 -> StallMem high 2 cycles per access; load returns 0xDEADBEEF in its 3rd cycle.
- WAIT_CYCLES=0: back-to-back stores to 0x4 and 0x8, then loads -> StallMem never high; data 1:1 with stores.
- Reset pulsed during cycle 2 of a 3-cycle store to 0x20 -> StallMem drops immediately; a later load of 0x20 returns the old value.
- ADDR_BITS=6: store 0x12345678 to 0x100 -> a load from 0x0 returns 0x12345678 (wrap).
- With DMEM_WS_MISALIGN_TRAP_EN: store to 0x22 -> word 0x20 unchanged, MemErr=1 and stays 1 through later aligned accesses until reset.

Source files
------------

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: data-memory responder that answers each load/store after WAIT_CYCLES stall cycles.
// Define DMEM_WS_MISALIGN_TRAP_EN to trap misaligned accesses into a sticky MemErr flag.
module dmem_waitstate #(
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallMem,
    output logic        MemErr
);

    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem_q [DEPTH];
    logic                  req;
    logic                  complete;
    logic                  misaligned;
    logic                  mem_we;
    logic [31:0]           load_data;
    logic [ADDR_BITS-1:0]  word_idx;

    assign req      = MemReadM | MemWriteM;
    assign word_idx = ALUOutM[ADDR_BITS+1:2];

`ifdef DMEM_WS_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic unused_addr;
    assign misaligned  = |ALUOutM[1:0];
    assign unused_addr = ^ALUOutM[31:ADDR_BITS+2];
    assign MemErr      = err_q;

    always_comb begin
        err_d = err_q | (complete & misaligned);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_addr;
    assign misaligned  = 1'b0;
    assign unused_addr = ^{ALUOutM[31:ADDR_BITS+2], ALUOutM[1:0]};
    assign MemErr      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        StallMem = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        StallMem = 1'b1;
                        cnt_d    = CNT_INIT;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    StallMem = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
        // The reset is asynchronous, so the combinational outputs must be silenced too.
        if (!reset) begin
            StallMem = 1'b0;
            complete = 1'b0;
        end
        load_data = misaligned ? 32'd0 : mem_q[word_idx];
        rdata_d   = (complete && MemReadM) ? load_data : rdata_q;
        ReadDataM = rdata_d;
        mem_we    = complete && MemWriteM && !misaligned;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= WriteDataM;
        end
    end

endmodule
